eval_window_ctrl: RTL and testbench

- Hardware sequencer for one-signal check windows: on a rising edge of `start` it samples `sig_a` against the expected level 1.
- `mode` selects single evaluation (first cycle only) or multiple evaluation (every cycle for `win_len` cycles).
- It counts passes and fails and reports one summarised result per window.
- Sits beside the DUT in self-checking benches and in silicon debug logic as the synthesizable counterpart of per-edge and triggered property checks.

---
 rtl/eval_window_ctrl.sv | 120 ++++++++++++
 tb/tb_eval_window_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/eval_window_ctrl.sv
// One-signal check-window sequencer: arms on a rising edge of start, samples sig_a
// once or for win_len cycles, and reports pass/fail counts and a summarised result.
module eval_window_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] win_len,
  input  logic             abort,
  input  logic             sig_a,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             vacuous,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state, state_next;
  logic             start_q;
  logic             rise;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx;
  logic             last_sample;
  logic             empty_win;

  assign rise        = start & ~start_q;
  assign last_sample = !mode_q || (idx == (len_q - ONE));
  assign empty_win   = mode && (win_len == '0);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a rise in DONE re-arms exactly as in IDLE
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (rise) state_next = empty_win ? DONE : EVAL;
        else      state_next = IDLE;
      end
      EVAL: begin
        if (abort)            state_next = IDLE;
        else if (last_sample) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      EVAL:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Window datapath: capture on arm, accumulate during EVAL, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q        <= 1'b0;
      mode_q         <= 1'b0;
      len_q          <= '0;
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= ALL_ONES;
      result         <= 1'b0;
      vacuous        <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (rise) begin
            mode_q         <= mode;
            len_q          <= win_len;
            idx            <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= ALL_ONES;
            result         <= empty_win;
            vacuous        <= empty_win;
          end
        end
        EVAL: begin
          if (!abort) begin
            if (sig_a) begin
              pass_cnt <= pass_cnt + ONE;
            end else begin
              fail_cnt <= fail_cnt + ONE;
              if (first_fail_idx == ALL_ONES) first_fail_idx <= idx;
            end
            idx <= idx + ONE;
            // Result is settled on the final sample so it is valid in the DONE cycle
            if (last_sample) result <= (fail_cnt == '0) && sig_a;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eval_window_ctrl.sv
// Directed bench for eval_window_ctrl: a table of complete windows plus hand-written
// sequences for reset-held start, abort with ignored re-trigger, re-arm in DONE, and mid-window reset.
module tb_eval_window_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] win_len;
  logic             abort;
  logic             sig_a;
  logic             busy;
  logic             done;
  logic             result;
  logic             vacuous;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  eval_window_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .win_len        (win_len),
    .abort          (abort),
    .sig_a          (sig_a),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .vacuous        (vacuous),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             mode;
    logic [CNT_W-1:0] len;
    logic [255:0]     pat;      // bit i = sig_a for sample i
    logic [CNT_W-1:0] exp_pass;
    logic [CNT_W-1:0] exp_fail;
    logic [CNT_W-1:0] exp_ffi;
    logic             exp_result;
    logic             exp_vac;
    int               exp_lat;  // edges from arm edge to the one that raises done
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"},    32'(busy),           32'd0);
    check({tag, " done"},    32'(done),           32'd0);
    check({tag, " result"},  32'(result),         32'd0);
    check({tag, " vacuous"}, 32'(vacuous),        32'd0);
    check({tag, " pass"},    32'(pass_cnt),       32'd0);
    check({tag, " fail"},    32'(fail_cnt),       32'd0);
    check({tag, " ffi"},     32'(first_fail_idx), 32'hff);
  endtask

  // Arm a window; returns just after the arming edge (negedge), start already low again.
  task automatic arm(input logic m, input logic [CNT_W-1:0] len);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    win_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int    cyc;
    int    busy_seen;
    string tag;
    tag = $sformatf("vec%0d", n);
    arm(v.mode, v.len);
    cyc       = 0;
    busy_seen = 0;
    while (!done && cyc < 300) begin
      if (busy) busy_seen++;
      sig_a = (cyc < 256) ? v.pat[cyc] : 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"},   32'(cyc),            32'(v.exp_lat));
    check({tag, " busy_cyc"},  32'(busy_seen),      32'(v.exp_lat));
    check({tag, " done"},      32'(done),           32'd1);
    check({tag, " busy@done"}, 32'(busy),           32'd0);
    check({tag, " pass"},      32'(pass_cnt),       32'(v.exp_pass));
    check({tag, " fail"},      32'(fail_cnt),       32'(v.exp_fail));
    check({tag, " ffi"},       32'(first_fail_idx), 32'(v.exp_ffi));
    check({tag, " result"},    32'(result),         32'(v.exp_result));
    check({tag, " vacuous"},   32'(vacuous),        32'(v.exp_vac));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done),          32'd0);
    check({tag, " hold_pass"},  32'(pass_cnt),      32'(v.exp_pass));
    check({tag, " hold_res"},   32'(result),        32'(v.exp_result));
  endtask

  initial begin
    // mode, len, pattern, pass, fail, ffi, result, vacuous, latency
    vecs[0] = '{1'b1, 8'd8,   256'h33, 8'd4,   8'd4, 8'd2,   1'b0, 1'b0, 8};
    vecs[1] = '{1'b0, 8'd8,   256'hcc, 8'd0,   8'd1, 8'd0,   1'b0, 1'b0, 1};
    vecs[2] = '{1'b1, 8'd0,   256'hff, 8'd0,   8'd0, 8'hff,  1'b1, 1'b1, 0};
    vecs[3] = '{1'b0, 8'd0,   256'h01, 8'd1,   8'd0, 8'hff,  1'b1, 1'b0, 1};
    vecs[4] = '{1'b1, 8'd1,   256'h00, 8'd0,   8'd1, 8'd0,   1'b0, 1'b0, 1};
    vecs[5] = '{1'b1, 8'd3,   256'h03, 8'd2,   8'd1, 8'd2,   1'b0, 1'b0, 3};
    vecs[6] = '{1'b1, 8'd5,   256'h05, 8'd2,   8'd3, 8'd1,   1'b0, 1'b0, 5};
    vecs[7] = '{1'b1, 8'd255, ~256'h0, 8'd255, 8'd0, 8'd255, 1'b1, 1'b0, 255};

    // Reset with start held high: rise is seen at the first edge after release
    rst_n   = 1'b0;
    start   = 1'b1;
    mode    = 1'b0;
    win_len = '0;
    abort   = 1'b0;
    sig_a   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("held_start busy", 32'(busy), 32'd1);
    check("held_start done", 32'(done), 32'd0);
    @(negedge clk);
    check("held_start done2",   32'(done),     32'd1);
    check("held_start result",  32'(result),   32'd1);
    check("held_start pass",    32'(pass_cnt), 32'd1);
    check("held_start fail",    32'(fail_cnt), 32'd0);
    start = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort at sample 5 with an ignored second rise at sample 3
    arm(1'b1, 8'd10);
    for (int k = 0; k < 5; k++) begin
      sig_a = (k != 1);
      start = (k == 3);
      @(negedge clk);
      check($sformatf("abort_seq busy k%0d", k), 32'(busy), 32'd1);
      check($sformatf("abort_seq done k%0d", k), 32'(done), 32'd0);
    end
    start = 1'b0;
    abort = 1'b1;
    sig_a = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy",   32'(busy),                 32'd0);
    check("abort done",   32'(done),                 32'd0);
    check("abort total",  32'(pass_cnt + fail_cnt),  32'd5);
    check("abort pass",   32'(pass_cnt),             32'd4);
    check("abort ffi",    32'(first_fail_idx),       32'd1);
    check("abort result", 32'(result),               32'd0);
    @(negedge clk);
    check("abort no_done", 32'(done), 32'd0);
    check("abort frozen",  32'(pass_cnt), 32'd4);

    // Abort together with rise in IDLE still arms
    abort = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    sig_a = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_rise busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort_rise done", 32'(done), 32'd1);
    check("abort_rise pass", 32'(pass_cnt), 32'd1);

    // Rise during the DONE cycle re-arms immediately
    arm(1'b1, 8'd2);
    sig_a = 1'b1;
    repeat (2) @(negedge clk);
    check("rearm done1", 32'(done), 32'd1);
    check("rearm pass1", 32'(pass_cnt), 32'd2);
    start = 1'b1;
    mode  = 1'b0;
    sig_a = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("rearm busy",  32'(busy),     32'd1);
    check("rearm clear", 32'(pass_cnt), 32'd0);
    @(negedge clk);
    check("rearm done2", 32'(done),           32'd1);
    check("rearm fail",  32'(fail_cnt),       32'd1);
    check("rearm ffi",   32'(first_fail_idx), 32'd0);
    check("rearm res",   32'(result),         32'd0);

    // Reset in the middle of a window clears everything, no done
    arm(1'b1, 8'd10);
    sig_a = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
